// File: rtl/aes_key_exp_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : aes_key_exp_ctrl_if
//  Brief    : Key-load and round-key handshake bundle for the AES-128 key
//             expansion sequencing controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface aes_key_exp_ctrl_if;
  logic       key_valid;
  logic       key_ready;
  logic       rk_valid;
  logic       rk_ready;
  logic [3:0] rk_index;
  logic       busy;
  logic       done;

  // Controller side: accepts keys, presents round keys
  modport master (
    input  key_valid,
    input  rk_ready,
    output key_ready,
    output rk_valid,
    output rk_index,
    output busy,
    output done
  );

  // Environment side: supplies keys, consumes round keys
  modport slave (
    output key_valid,
    output rk_ready,
    input  key_ready,
    input  rk_valid,
    input  rk_index,
    input  busy,
    input  done
  );
endinterface
`default_nettype wire

// File: rtl/aes_key_exp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : aes_key_exp_ctrl
//  Brief    : Sequencing controller for the AES-128 key expansion datapath.
//             Loads a cipher key, presents each round key with valid/ready and
//             steps the datapath one expansion per consumed round key.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_key_exp_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int RC_WIDTH   = 10,
  parameter int G_LATENCY  = 0
) (
  input  wire logic                        clk,
  input  wire logic                        rst_n,
  aes_key_exp_ctrl_if.master               bus,
  output logic                             key_MUX1,
  output logic                             key_MUX2,
  output logic                             FF1_enable,
  output logic [$clog2(RC_WIDTH)-1:0]      RC_sig
);

  localparam int         RC_W       = $clog2(RC_WIDTH);
  localparam logic [3:0] C_LAST_IDX = 4'(NUM_ROUNDS);
  localparam logic [2:0] C_G_LAT    = 3'(G_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_WAIT_G  = 2'd2,
    S_EXPAND  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_rk_index;
  logic [3:0]      w_rk_index_nxt;
  logic [2:0]      r_wait_cnt;
  logic [2:0]      w_wait_cnt_nxt;
  logic            r_done;
  logic            w_done_nxt;

  logic            w_key_ready;
  logic            w_rk_valid;
  logic            w_busy;
  logic            w_mux1;
  logic            w_mux2;
  logic            w_ff1;
  logic            w_rc_en;
  logic [RC_W-1:0] w_rc_idx;

  // Round-constant select follows the round index; narrow or widen to RC_W
  if (RC_W <= 4) begin : g_rc_trunc
    assign w_rc_idx = r_rk_index[RC_W-1:0];
  end else begin : g_rc_ext
    assign w_rc_idx = {{(RC_W-4){1'b0}}, r_rk_index};
  end

  // State, round index, G wait counter and done pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rk_index <= 4'd0;
      r_wait_cnt <= 3'd0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rk_index <= w_rk_index_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Next-state decode and datapath control outputs
  always_comb begin
    w_state_nxt    = r_state;
    w_rk_index_nxt = r_rk_index;
    w_wait_cnt_nxt = r_wait_cnt;
    w_done_nxt     = 1'b0;
    w_key_ready    = 1'b0;
    w_rk_valid     = 1'b0;
    w_busy         = 1'b0;
    w_mux1         = 1'b0;
    w_mux2         = 1'b0;
    w_ff1          = 1'b0;
    w_rc_en        = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_key_ready = 1'b1;
        // Key is captured by the datapath on the handshake edge itself;
        // gated by rst_n so nothing is enabled while reset is held.
        w_ff1       = bus.key_valid & rst_n;
        if (bus.key_valid) begin
          w_rk_index_nxt = 4'd0;
          w_state_nxt    = S_PRESENT;
        end
      end

      S_PRESENT: begin
        w_rk_valid = 1'b1;
        w_busy     = 1'b1;
        w_mux1     = 1'b1;
        w_mux2     = 1'b1;
        w_rc_en    = 1'b1;
        if (bus.rk_ready) begin
          if (r_rk_index >= C_LAST_IDX) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else if (G_LATENCY == 0) begin
            w_state_nxt = S_EXPAND;
          end else begin
            w_wait_cnt_nxt = C_G_LAT;
            w_state_nxt    = S_WAIT_G;
          end
        end
      end

      S_WAIT_G: begin
        // G input and round constant are already steady; let them settle
        w_busy         = 1'b1;
        w_mux1         = 1'b1;
        w_mux2         = 1'b1;
        w_rc_en        = 1'b1;
        w_wait_cnt_nxt = r_wait_cnt - 3'd1;
        if (r_wait_cnt <= 3'd1) begin
          w_state_nxt = S_EXPAND;
        end
      end

      S_EXPAND: begin
        w_busy      = 1'b1;
        w_mux1      = 1'b1;
        w_mux2      = 1'b1;
        w_ff1       = 1'b1;
        w_rc_en     = 1'b1;
        w_state_nxt = S_PRESENT;
        // Index never wraps past the final round
        if (r_rk_index < C_LAST_IDX) begin
          w_rk_index_nxt = r_rk_index + 4'd1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.key_ready = w_key_ready;
  assign bus.rk_valid  = w_rk_valid;
  assign bus.rk_index  = r_rk_index;
  assign bus.busy      = w_busy;
  assign bus.done      = r_done;
  assign key_MUX1      = w_mux1;
  assign key_MUX2      = w_mux2;
  assign FF1_enable    = w_ff1;
  assign RC_sig        = w_rc_en ? w_rc_idx : '0;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_exp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_key_exp_ctrl
//  Brief    : Self-checking bench for aes_key_exp_ctrl with a behavioural
//             AES-128 key expansion datapath and a round-key scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aes_key_exp_ctrl;

  localparam logic [127:0] K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RKA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic clk = 1'b0;
  logic rst_n;
  logic sel;
  logic [127:0] key_vector;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_key_exp_ctrl_if if0 ();
  aes_key_exp_ctrl_if if1 ();

  logic mux1_0, mux2_0, ff1_0, mux1_1, mux2_1, ff1_1;
  logic [3:0] rc0, rc1;

  aes_key_exp_ctrl #(.NUM_ROUNDS(10), .RC_WIDTH(10), .G_LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0),
    .key_MUX1(mux1_0), .key_MUX2(mux2_0), .FF1_enable(ff1_0), .RC_sig(rc0));

  aes_key_exp_ctrl #(.NUM_ROUNDS(10), .RC_WIDTH(10), .G_LATENCY(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1),
    .key_MUX1(mux1_1), .key_MUX2(mux2_1), .FF1_enable(ff1_1), .RC_sig(rc1));

  // ---------------- AES helpers ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon_tab(input logic [3:0] i);
    case (i)
      4'd0: return 8'h01; 4'd1: return 8'h02; 4'd2: return 8'h04; 4'd3: return 8'h08;
      4'd4: return 8'h10; 4'd5: return 8'h20; 4'd6: return 8'h40; 4'd7: return 8'h80;
      4'd8: return 8'h1b; 4'd9: return 8'h36; default: return 8'h00;
    endcase
  endfunction

  // Reference key schedule: round key n of a cipher key
  function automatic logic [127:0] sw_round_key(input logic [127:0] key, input int n);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i <= 4*n+3; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endfunction

  // Behavioural expansion datapath driven by the controller
  function automatic logic [127:0] dp_next(input logic [127:0] rk, input logic m1,
      input logic m2, input logic [3:0] rc, input logic [127:0] kv);
    logic [31:0] g, t, n0, n1, n2, n3;
    if (!m1) return kv;
    g  = m2 ? rk[31:0] : 32'h0;
    t  = sub_word({g[23:0], g[31:24]}) ^ {rcon_tab(rc), 24'h0};
    n0 = rk[127:96] ^ t;
    n1 = rk[95:64]  ^ n0;
    n2 = rk[63:32]  ^ n1;
    n3 = rk[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  logic [127:0] dp_rk0, dp_rk1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dp_rk0 <= '0;
    else if (ff1_0) dp_rk0 <= dp_next(dp_rk0, mux1_0, mux2_0, rc0, key_vector);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dp_rk1 <= '0;
    else if (ff1_1) dp_rk1 <= dp_next(dp_rk1, mux1_1, mux2_1, rc1, key_vector);
  end

  // ---------------- observed-instance mux ----------------
  logic m_kv, m_kr, m_rv, m_rr, m_busy, m_done, m_mux1, m_mux2, m_ff1;
  logic [3:0] m_idx, m_rc;
  logic [127:0] m_rk;
  always_comb begin
    if (sel) begin
      m_kv = if1.key_valid; m_kr = if1.key_ready; m_rv = if1.rk_valid; m_rr = if1.rk_ready;
      m_busy = if1.busy; m_done = if1.done; m_idx = if1.rk_index; m_rc = rc1;
      m_mux1 = mux1_1; m_mux2 = mux2_1; m_ff1 = ff1_1; m_rk = dp_rk1;
    end else begin
      m_kv = if0.key_valid; m_kr = if0.key_ready; m_rv = if0.rk_valid; m_rr = if0.rk_ready;
      m_busy = if0.busy; m_done = if0.done; m_idx = if0.rk_index; m_rc = rc0;
      m_mux1 = mux1_0; m_mux2 = mux2_0; m_ff1 = ff1_0; m_rk = dp_rk0;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_key(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] key;
  } sb_t;

  sb_t          exp_q[$];
  logic [127:0] got_rk [0:15];
  int           acc_cyc [0:15];
  int           rc_log[$];
  int           wait_log[$];
  int           t0 = 0, done_cyc = -1, done_cnt = 0, n_acc = 0, run = 0, mux1_bad = 0;

  // Scoreboard and sequence monitor, sampled well before the next rising edge
  always @(negedge clk) begin
    sb_t item;
    #3;
    if (m_done) begin
      done_cnt++;
      done_cyc = cyc - t0;
    end
    if (m_kv && m_kr) begin
      for (int n = 0; n <= 10; n++) begin
        item.idx = 4'(n);
        item.key = sw_round_key(key_vector, n);
        exp_q.push_back(item);
      end
      t0 = cyc; done_cnt = 0; done_cyc = -1; n_acc = 0; run = 0; mux1_bad = 0;
      rc_log.delete(); wait_log.delete();
      for (int i = 0; i < 16; i++) acc_cyc[i] = -1;
    end
    if (m_rv && m_rr) begin
      chk("sb_nonempty", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        item = exp_q.pop_front();
        chk("rk_index", int'(m_idx), int'(item.idx));
        chk_key("round_key", m_rk, item.key);
      end
      got_rk[m_idx]  = m_rk;
      acc_cyc[m_idx] = cyc - t0;
      n_acc++;
    end
    if (m_ff1 && m_mux1) begin
      rc_log.push_back(int'(m_rc));
      wait_log.push_back(run);
    end
    if (m_busy && !m_rv && !m_ff1) run++;
    else run = 0;
    if (m_busy && !m_mux1) mux1_bad++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_kv(input logic v);
    if (sel) if1.key_valid = v; else if0.key_valid = v;
  endtask

  task automatic set_rdy(input logic v);
    if (sel) if1.rk_ready = v; else if0.rk_ready = v;
  endtask

  task automatic load_key(input logic [127:0] k);
    key_vector = k;
    set_kv(1'b1);
    step();
    set_kv(1'b0);
  endtask

  task automatic wait_done(input string tag);
    int i;
    i = 0;
    while (!m_done && i < 300) begin
      step();
      i++;
    end
    chk(tag, int'(m_done), 1);
  endtask

  task automatic check_rc_log(input string tag);
    chk({tag, "_rc_count"}, rc_log.size(), 10);
    for (int i = 0; i < rc_log.size(); i++) chk({tag, "_rc_sig"}, rc_log[i], i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int i;
    logic [127:0] rk3;
    int dc;

    sel = 1'b0; rst_n = 1'b0; key_vector = '0;
    if0.key_valid = 1'b0; if0.rk_ready = 1'b0;
    if1.key_valid = 1'b0; if1.rk_ready = 1'b0;
    step(); step();

    // Reset state
    chk("rst_key_ready", int'(if0.key_ready), 1);
    chk("rst_rk_valid",  int'(if0.rk_valid), 0);
    chk("rst_busy",      int'(if0.busy), 0);
    chk("rst_done",      int'(if0.done), 0);
    chk("rst_rk_index",  int'(if0.rk_index), 0);
    chk("rst_mux1",      int'(mux1_0), 0);
    chk("rst_mux2",      int'(mux2_0), 0);
    chk("rst_ff1",       int'(ff1_0), 0);
    chk("rst_rc_sig",    int'(rc0), 0);
    rst_n = 1'b1;
    step();

    // Full expansion, rk_ready held high
    set_rdy(1'b1);
    load_key(K);
    wait_done("s1_done_seen");
    step(); step(); step();
    chk("s1_rk0_cycle",  acc_cyc[0], 1);
    chk("s1_rk1_cycle",  acc_cyc[1], 3);
    chk("s1_rk10_cycle", acc_cyc[10], 21);
    chk("s1_done_cycle", done_cyc, 22);
    chk("s1_done_count", done_cnt, 1);
    chk("s1_accepted",   n_acc, 11);
    chk("s1_sb_empty",   exp_q.size(), 0);
    chk_key("s1_rk0", got_rk[0], K);
    chk_key("s1_rk1", got_rk[1], RK1);
    chk_key("s1_rk10", got_rk[10], RKA);
    check_rc_log("s1");
    chk("s1_mux1_busy_zero", mux1_bad, 0);

    // Backpressure at rk_index 3
    load_key(K);
    rk3 = sw_round_key(K, 3);
    i = 0;
    while (!(m_ff1 && m_mux1 && m_idx == 4'd2) && i < 100) begin step(); i++; end
    chk("s2_reach_idx2", int'(m_ff1 && m_idx == 4'd2), 1);
    set_rdy(1'b0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("s2_bp_rk_valid", int'(m_rv), 1);
      chk("s2_bp_rk_index", int'(m_idx), 3);
      chk("s2_bp_ff1", int'(m_ff1), 0);
      chk_key("s2_bp_round_key", m_rk, rk3);
    end
    set_rdy(1'b1);
    wait_done("s2_done_seen");
    chk("s2_accepted", n_acc, 11);
    chk("s2_sb_empty", exp_q.size(), 0);
    step();

    // key_valid while busy is ignored; new key accepted in the done cycle
    load_key(K2);
    i = 0;
    while (!(m_rv && m_idx == 4'd5) && i < 100) begin step(); i++; end
    chk("s3_reach_idx5", int'(m_rv && m_idx == 4'd5), 1);
    chk("s3_busy_key_ready", int'(m_kr), 0);
    key_vector = {$urandom, $urandom, $urandom, $urandom};
    set_kv(1'b1);
    step();
    set_kv(1'b0);
    key_vector = K;
    wait_done("s3_done_seen");
    chk("s3_done_key_ready", int'(m_kr), 1);
    chk("s3_accepted", n_acc, 11);
    chk_key("s3_rk0", got_rk[0], K2);
    chk_key("s3_rk10", got_rk[10], sw_round_key(K2, 10));
    load_key(K);
    chk("s3_next_rk_valid", int'(m_rv), 1);
    chk("s3_next_rk_index", int'(m_idx), 0);
    chk_key("s3_next_rk0", m_rk, K);

    // Reset mid-sequence at rk_index 4
    i = 0;
    while (!(m_rv && m_idx == 4'd4) && i < 100) begin step(); i++; end
    chk("s4_reach_idx4", int'(m_rv && m_idx == 4'd4), 1);
    rst_n = 1'b0;
    #1;
    chk("s4_rst_rk_valid",  int'(m_rv), 0);
    chk("s4_rst_busy",      int'(m_busy), 0);
    chk("s4_rst_rk_index",  int'(m_idx), 0);
    chk("s4_rst_key_ready", int'(m_kr), 1);
    chk("s4_rst_ff1",       int'(m_ff1), 0);
    chk("s4_rst_mux1",      int'(m_mux1), 0);
    exp_q.delete();
    dc = done_cnt;
    step(); step();
    rst_n = 1'b1;
    step(); step(); step();
    chk("s4_no_done", done_cnt, dc);
    load_key(K2);
    wait_done("s4_done_seen");
    chk("s4_accepted", n_acc, 11);
    chk("s4_sb_empty", exp_q.size(), 0);
    chk_key("s4_rk0", got_rk[0], K2);
    step();

    // G_LATENCY = 3 instance
    sel = 1'b1;
    set_rdy(1'b1);
    step();
    load_key(K);
    wait_done("s5_done_seen");
    step();
    chk("s5_rk1_cycle",  acc_cyc[1], 6);
    chk("s5_rk10_cycle", acc_cyc[10], 51);
    chk("s5_done_cycle", done_cyc, 52);
    chk("s5_accepted",   n_acc, 11);
    chk("s5_sb_empty",   exp_q.size(), 0);
    chk_key("s5_rk1", got_rk[1], RK1);
    chk_key("s5_rk10", got_rk[10], RKA);
    chk("s5_wait_count", wait_log.size(), 10);
    for (int w = 0; w < wait_log.size(); w++) chk("s5_wait_g_cycles", wait_log[w], 3);
    check_rc_log("s5");
    chk("s5_mux1_busy_zero", mux1_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
